// File: rtl/tdc_batch_sequencer.sv
// Batch sequencer: collects 2^LOG2_N TDC interval samples, reduces them to mean/min/max
// and streams a fixed-length report frame over a valid/ready byte interface.
module tdc_batch_sequencer #(
    parameter int CNT_W       = 32,
    parameter int LOG2_N      = 4,
    parameter int TIMEOUT_CYC = 200_000_000,
    parameter bit CONTINUOUS  = 1'b1
) (
    input  logic             clk_200m,
    input  logic             rst_n,
    input  logic             start,
    input  logic             meas_valid,
    input  logic [CNT_W-1:0] meas_interval,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [3:0]       led
);

    localparam int SUM_W       = CNT_W + LOG2_N;
    localparam int CNTR_W      = LOG2_N + 1;
    localparam int FRAME_BYTES = 3 + 3 * (CNT_W / 8);
    localparam int REST_W      = (FRAME_BYTES - 1) * 8;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNTR_W-1:0] N_LAST   = CNTR_W'(2 ** LOG2_N - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BYTES - 1);
    localparam logic [7:0]        HEADER   = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_LATCH,
        S_SEND
    } state_e;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]    min_q, min_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [CNTR_W-1:0]   count_q, count_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                timeout_q, timeout_d;
    logic                overrun_q, overrun_d;
    logic [REST_W-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic [3:0]          led_q, led_d;

    logic                enter_collect;
    logic [CNT_W-1:0]    mean;
    logic [3*CNT_W-1:0]  payload;

    assign mean    = CNT_W'(sum_q >> LOG2_N);
    assign payload = timeout_q ? '0 : {mean, min_q, max_q};

    // NOTE: every _d defaults to its _q before the case, so no path leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        min_d         = min_q;
        max_d         = max_q;
        count_d       = count_q;
        tmo_d         = tmo_q;
        timeout_d     = timeout_q;
        overrun_d     = overrun_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        led_d         = led_q;
        enter_collect = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_COLLECT;
                    enter_collect = 1'b1;
                end
            end

            S_COLLECT: begin
                // A sample in the expiry cycle wins over the watchdog.
                if (meas_valid) begin
                    sum_d   = sum_q + SUM_W'(meas_interval);
                    min_d   = (meas_interval < min_q) ? meas_interval : min_q;
                    max_d   = (meas_interval > max_q) ? meas_interval : max_q;
                    count_d = count_q + 1'b1;
                    tmo_d   = '0;
                    if (count_q == N_LAST) begin
                        state_d = S_LATCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_LATCH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_LATCH: begin
                frame_d    = {6'b0, overrun_q, timeout_q, 8'(count_q), payload};
                overrun_d  = meas_valid;
                tx_data_d  = HEADER;
                tx_valid_d = 1'b1;
                idx_d      = '0;
                led_d[2]   = timeout_q;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (meas_valid) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (idx_q == IDX_LAST) begin
                        tx_valid_d = 1'b0;
                        led_d[3]   = ~led_q[3];
                        if (CONTINUOUS) begin
                            state_d       = S_COLLECT;
                            enter_collect = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tx_data_d = frame_q[REST_W-1 -: 8];
                        frame_d   = frame_q << 8;
                        idx_d     = idx_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (enter_collect) begin
            sum_d     = '0;
            min_d     = '1;
            max_d     = '0;
            count_d   = '0;
            tmo_d     = '0;
            timeout_d = 1'b0;
        end

        busy_d   = (state_d != S_IDLE);
        led_d[0] = (state_d == S_COLLECT);
        led_d[1] = (state_d == S_SEND);
    end

    // NOTE: state is updated only here, with non-blocking assignments; the
    // combinational block above uses blocking assignments.
    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frame_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            min_q      <= min_d;
            max_q      <= max_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            led_q      <= led_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign led      = led_q;

endmodule

// File: tb/tb_tdc_batch_sequencer.sv
// Self-checking bench for tdc_batch_sequencer: randomized batches compared against a
// frame model built from the batch rules (sum/N, min, max, flags) with plain arithmetic.
module tb_tdc_batch_sequencer;

    localparam int CNT_W       = 32;
    localparam int LOG2_N      = 2;
    localparam int N           = 1 << LOG2_N;
    localparam int TIMEOUT_CYC = 1000;
    localparam int FRAME_BYTES = 3 + 3 * (CNT_W / 8);
    localparam int RX_BOUND    = 3000;

    logic             clk_200m = 1'b0;
    logic             rst_n;
    logic             start;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_interval;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [3:0]       led;

    int checks = 0;
    int errors = 0;

    logic [31:0] smp_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          rx_cycles;

    tdc_batch_sequencer #(
        .CNT_W(CNT_W),
        .LOG2_N(LOG2_N),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CONTINUOUS(1'b0)
    ) dut (
        .clk_200m(clk_200m),
        .rst_n(rst_n),
        .start(start),
        .meas_valid(meas_valid),
        .meas_interval(meas_interval),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .led(led)
    );

    always #5 clk_200m = ~clk_200m;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "bench did not complete");
    end

    // Reference frame from the batch contents in smp_q.
    function automatic void build_expected(input bit tmo, input bit ovr);
        longint unsigned sum = 0;
        logic [31:0] mn = 32'hFFFF_FFFF;
        logic [31:0] mx = 32'h0;
        logic [31:0] fld[3];
        foreach (smp_q[i]) begin
            sum += 64'(smp_q[i]);
            if (smp_q[i] < mn) mn = smp_q[i];
            if (smp_q[i] > mx) mx = smp_q[i];
        end
        fld[0] = 32'(sum / N);
        fld[1] = mn;
        fld[2] = mx;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back({6'b0, ovr, tmo});
        exp_q.push_back(8'(smp_q.size()));
        for (int f = 0; f < 3; f++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(tmo ? 8'h00 : fld[f][8*b +: 8]);
            end
        end
    endfunction

    function automatic int first_diff();
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (rx_q[i] !== exp_q[i]) return i;
        end
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 8'h00;
    endfunction

    task automatic arm();
        smp_q.delete();
        start = 1'b1;
        @(negedge clk_200m);
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] v);
        smp_q.push_back(v);
        meas_valid    = 1'b1;
        meas_interval = v;
        @(negedge clk_200m);
        meas_valid    = 1'b0;
        meas_interval = $urandom();
    endtask

    // Collects one frame; rx_cycles counts cycles with tx_valid high.
    task automatic receive_frame(input int stall_after, input int stall_len,
                                 input bit rand_ready, input bit pulse_meas);
        int   stall_cnt  = 0;
        int   guard      = 0;
        bit   seen_valid = 1'b0;
        bit   prev_hold  = 1'b0;
        bit   pulsed     = 1'b0;
        logic [7:0] prev_data = 8'h00;
        rx_q.delete();
        rx_cycles = 0;
        while (rx_q.size() < FRAME_BYTES && guard < RX_BOUND) begin
            if (prev_hold) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: tx_valid=%0b tx_data=%02h, required 1 and %02h",
                             tx_valid, tx_data, prev_data);
                end
            end else if (seen_valid) begin
                checks++;
                if (tx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_mid_frame: tx_valid=%0b after %0d bytes, required 1",
                             tx_valid, rx_q.size());
                end
            end
            if (tx_valid === 1'b1) begin
                seen_valid = 1'b1;
                rx_cycles++;
            end
            if (tx_valid === 1'b1 && rx_q.size() == stall_after && stall_cnt < stall_len) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (pulse_meas && tx_valid === 1'b1) begin
                meas_valid    = !pulsed || ($urandom_range(0, 1) == 1);
                meas_interval = $urandom();
                pulsed        = pulsed | meas_valid;
            end else begin
                meas_valid = 1'b0;
            end
            if (tx_valid === 1'b1 && tx_ready) rx_q.push_back(tx_data);
            prev_hold = (tx_valid === 1'b1) && !tx_ready;
            prev_data = tx_data;
            @(negedge clk_200m);
            guard++;
        end
        meas_valid = 1'b0;
        tx_ready   = 1'b1;
        checks++;
        if (rx_q.size() != FRAME_BYTES) begin
            errors++;
            $display("FAIL rx_bound: received %0d bytes within %0d cycles, required %0d",
                     rx_q.size(), RX_BOUND, FRAME_BYTES);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: tx_valid=%0b busy=%0b, required 0 and 0", tx_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; meas_valid = 1'b0; meas_interval = '0; tx_ready = 1'b1;
        repeat (3) @(negedge clk_200m);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || led !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%02h busy=%0b led=%h, required 0/00/0/0",
                     tx_valid, tx_data, busy, led);
        end
        rst_n = 1'b1;
        @(negedge clk_200m);
    endtask

    task automatic test_normal();
        int diff;
        meas_valid = 1'b1; meas_interval = 32'd999;   // ignored in IDLE
        @(negedge clk_200m);
        meas_valid = 1'b0;
        arm();
        checks++;
        if (busy !== 1'b1 || led !== 4'b0001) begin
            errors++;
            $display("FAIL arm_busy: busy=%0b led=%b, required 1 and 0001", busy, led);
        end
        feed(100);
        feed(200);
        start = 1'b1;                                  // ignored while busy
        feed(300);
        start = 1'b0;
        feed(400);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL latch_cycle: tx_valid=%0b, required 0", tx_valid);
        end
        @(negedge clk_200m);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || led[1] !== 1'b1) begin
            errors++;
            $display("FAIL first_byte_latency: valid=%0b data=%02h led1=%0b, required 1/a5/1",
                     tx_valid, tx_data, led[1]);
        end
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL normal_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        checks++;
        if (rx_at(6) !== 8'hFA || rx_at(10) !== 8'h64 || rx_at(14) !== 8'h90) begin
            errors++;
            $display("FAIL normal_fields: mean_lsb=%02h min_lsb=%02h max_lsb=%02h, required fa/64/90",
                     rx_at(6), rx_at(10), rx_at(14));
        end
        checks++;
        if (rx_cycles != FRAME_BYTES) begin
            errors++;
            $display("FAIL back_to_back: frame took %0d valid cycles, required %0d", rx_cycles, FRAME_BYTES);
        end
        checks++;
        if (led !== 4'b1000) begin
            errors++;
            $display("FAIL led_after_frame: led=%b, required 1000", led);
        end
    endtask

    task automatic test_back_pressure();
        int diff;
        arm();
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_200m);
            feed($urandom());
        end
        receive_frame(5, 50, 1'b0, 1'b0);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL backpressure_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        checks++;
        if (rx_cycles != FRAME_BYTES + 50) begin
            errors++;
            $display("FAIL backpressure_cycles: %0d valid cycles, required %0d", rx_cycles, FRAME_BYTES + 50);
        end
    endtask

    task automatic test_timeout();
        int diff;
        arm();
        feed(10);
        feed(20);
        repeat (TIMEOUT_CYC - 1) @(negedge clk_200m);
        checks++;
        if (tx_valid !== 1'b0 || led[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: valid=%0b led0=%0b, required 0 and 1", tx_valid, led[0]);
        end
        @(negedge clk_200m);
        checks++;
        if (tx_valid !== 1'b0 || led[0] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_latch: valid=%0b led0=%0b, required 0 and 0", tx_valid, led[0]);
        end
        @(negedge clk_200m);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL timeout_latency: valid=%0b data=%02h, required 1 and a5", tx_valid, tx_data);
        end
        receive_frame(-1, 0, 1'b1, 1'b0);
        build_expected(1'b1, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL timeout_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        checks++;
        if (led[2] !== 1'b1 || rx_at(1) !== 8'h01 || rx_at(2) !== 8'h02) begin
            errors++;
            $display("FAIL timeout_flags: led2=%0b flags=%02h count=%02h, required 1/01/02",
                     led[2], rx_at(1), rx_at(2));
        end
    endtask

    task automatic test_zero_sample_timeout();
        int diff;
        arm();
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b1, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0 || rx_at(1) !== 8'h01 || rx_at(2) !== 8'h00) begin
            errors++;
            $display("FAIL zero_timeout_frame: flags=%02h count=%02h first diff %0d, required 01/00/-1",
                     rx_at(1), rx_at(2), diff);
        end
    endtask

    task automatic test_timeout_edge();
        int diff;
        arm();
        feed(10);
        feed(20);
        repeat (TIMEOUT_CYC - 1) @(negedge clk_200m);
        feed(30);
        checks++;
        if (led[0] !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL edge_sample_kept: led0=%0b valid=%0b, required 1 and 0", led[0], tx_valid);
        end
        repeat (TIMEOUT_CYC - 1) @(negedge clk_200m);
        feed(40);
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL edge_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        checks++;
        if (led[2] !== 1'b0) begin
            errors++;
            $display("FAIL edge_led2: led2=%0b, required 0", led[2]);
        end
    endtask

    task automatic test_overrun();
        int diff;
        arm();
        for (int i = 0; i < N; i++) feed($urandom_range(1, 5000));
        receive_frame(-1, 0, 1'b1, 1'b1);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL overrun_current: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        arm();
        feed(5); feed(5); feed(5); feed(6);
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b0, 1'b1);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL overrun_next: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        checks++;
        if (rx_at(1) !== 8'h02 || rx_at(6) !== 8'h05) begin
            errors++;
            $display("FAIL overrun_fields: flags=%02h mean_lsb=%02h, required 02 and 05", rx_at(1), rx_at(6));
        end
    endtask

    task automatic test_width_edge();
        int diff;
        int bad = 0;
        arm();
        for (int i = 0; i < N; i++) feed(32'hFFFF_FFFF);
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL width_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
        for (int i = 3; i < FRAME_BYTES; i++) if (rx_at(i) !== 8'hFF) bad++;
        checks++;
        if (bad != 0 || rx_at(1) !== 8'h00) begin
            errors++;
            $display("FAIL width_fields: %0d non-ff payload bytes, flags=%02h, required 0 and 00",
                     bad, rx_at(1));
        end
    endtask

    task automatic test_random();
        int diff;
        for (int b = 0; b < 4; b++) begin
            arm();
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 4)) @(negedge clk_200m);
                feed($urandom());
            end
            receive_frame(-1, 0, 1'b1, 1'b0);
            build_expected(1'b0, 1'b0);
            diff = first_diff();
            checks++;
            if (diff >= 0) begin
                errors++;
                $display("FAIL random_frame[%0d]: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                         b, diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int diff;
        int got   = 0;
        int guard = 0;
        int leaks = 0;
        arm();
        for (int i = 0; i < N; i++) feed($urandom());
        tx_ready = 1'b1;
        while (got < 5 && guard < 100) begin
            if (tx_valid === 1'b1) got++;
            @(negedge clk_200m);
            guard++;
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: tx_valid=%0b after %0d bytes, required 1", tx_valid, got);
        end
        tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || led !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b busy=%0b led=%h, required 0/0/0", tx_valid, busy, led);
        end
        @(negedge clk_200m);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        repeat (20) begin
            @(negedge clk_200m);
            if (tx_valid !== 1'b0 || busy !== 1'b0) leaks++;
        end
        checks++;
        if (leaks != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d cycles with valid or busy, required 0", leaks);
        end
        arm();
        for (int i = 0; i < N; i++) feed($urandom());
        receive_frame(-1, 0, 1'b0, 1'b0);
        build_expected(1'b0, 1'b0);
        diff = first_diff();
        checks++;
        if (diff >= 0) begin
            errors++;
            $display("FAIL post_reset_frame: byte %0d is %02h, required %02h (%0d of %0d bytes)",
                     diff, rx_at(diff), exp_at(diff), rx_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_pressure();
        test_timeout();
        test_zero_sample_timeout();
        test_timeout_edge();
        test_overrun();
        test_width_edge();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
